// File: rtl/multicycle_control.sv
// multicycle_control: IF/ID/EX/MEM/WB control FSM for the 16-bit TSC CPU (shared memory port, ALU, register file).
// Optional macro MEM_WAIT_EN: IF and MEM stall on mem_ready; without it every memory access completes in one cycle.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif

module multicycle_control #(
  parameter int WORD_SIZE    = `WORD_SIZE,
  parameter int JAL_LINK_REG = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] instr,
  input  logic                 bcond,
  input  logic                 mem_ready,
  output logic                 i_or_d,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [2:0]           alu_op,
  output logic                 rt_dest,
  output logic                 link_dest,
  output logic [1:0]           reg_src,
  output logic                 reg_write,
  output logic                 pc_write,
  output logic [1:0]           pc_source,
  output logic                 output_valid,
  output logic                 is_halted,
  output logic [15:0]          num_inst
);

  localparam logic [3:0] OP_ADI = 4'd4, OP_ORI = 4'd5, OP_LHI = 4'd6, OP_LWD = 4'd7,
                         OP_SWD = 4'd8, OP_JMP = 4'd9, OP_JAL = 4'd10, OP_RTYPE = 4'd15;
  localparam logic [5:0] FN_JPR = 6'd25, FN_JRL = 6'd26, FN_WWD = 6'd28, FN_HLT = 6'd29;
  localparam logic [2:0] FUNC_ADD = 3'd0, FUNC_SUB = 3'd1, FUNC_ORR = 3'd3, FUNC_SHL = 3'd6;

  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_t;

  state_t state, next_state;
  logic [3:0] opcode;
  logic [5:0] func;
  logic mem_done, retire;
  logic is_rtype, is_alu_r, is_branch, is_imm_alu, is_lwd, is_swd, wb_valid;
  logic [WORD_SIZE-11:0] unused_bits;

  assign opcode = instr[WORD_SIZE-1 -: 4];
  assign func   = instr[5:0];
  assign unused_bits = {instr[WORD_SIZE-5:6], 2'(JAL_LINK_REG)};

`ifdef MEM_WAIT_EN
  assign mem_done = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_done = 1'b1;
`endif

  assign is_rtype   = (opcode == OP_RTYPE);
  assign is_alu_r   = is_rtype && (func[5:3] == 3'd0);
  assign is_branch  = (opcode[3:2] == 2'b00);
  assign is_imm_alu = (opcode == OP_ADI) || (opcode == OP_ORI) || (opcode == OP_LHI);
  assign is_lwd     = (opcode == OP_LWD);
  assign is_swd     = (opcode == OP_SWD);
  // Unknown opcodes/funcs still walk through WB but never write a register
  assign wb_valid   = is_alu_r || is_imm_alu || is_lwd;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IF;
    else          state <= next_state;
  end

  always_comb begin
    next_state   = state;
    i_or_d       = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'd0;
    alu_op       = 3'd0;
    rt_dest      = 1'b0;
    link_dest    = 1'b0;
    reg_src      = 2'd0;
    reg_write    = 1'b0;
    pc_write     = 1'b0;
    pc_source    = 2'd0;
    output_valid = 1'b0;
    is_halted    = 1'b0;
    if (reset_n) begin
      case (state)
        S_IF: begin
          mem_read = 1'b1;
          ir_write = mem_done;
          if (mem_done) next_state = S_ID;
        end
        S_ID: begin
          next_state = S_EX;
          if (opcode == OP_JMP || opcode == OP_JAL) begin
            pc_write   = 1'b1;
            pc_source  = 2'd2;
            reg_write  = (opcode == OP_JAL);
            link_dest  = (opcode == OP_JAL);
            reg_src    = (opcode == OP_JAL) ? 2'd2 : 2'd0;
            next_state = S_IF;
          end else if (is_rtype && (func == FN_JPR || func == FN_JRL)) begin
            pc_write   = 1'b1;
            pc_source  = 2'd3;
            reg_write  = (func == FN_JRL);
            link_dest  = (func == FN_JRL);
            reg_src    = (func == FN_JRL) ? 2'd2 : 2'd0;
            next_state = S_IF;
          end else if (is_rtype && func == FN_WWD) begin
            output_valid = 1'b1;
            pc_write     = 1'b1;
            next_state   = S_IF;
          end else if (is_rtype && func == FN_HLT) begin
            next_state = S_HALT;
          end
        end
        S_EX: begin
          // rs is always the A operand; branches compare rs against rt/zero
          alu_src_a  = 1'b1;
          next_state = S_WB;
          if (is_alu_r) begin
            alu_op = func[2:0];
          end else if (opcode == OP_ADI || is_lwd || is_swd) begin
            alu_src_b = 2'd1;
            alu_op    = FUNC_ADD;
            if (is_lwd || is_swd) next_state = S_MEM;
          end else if (opcode == OP_ORI) begin
            alu_src_b = 2'd3;
            alu_op    = FUNC_ORR;
          end else if (opcode == OP_LHI) begin
            alu_src_b = 2'd3;
            alu_op    = FUNC_SHL;
          end else if (is_branch) begin
            alu_op     = FUNC_SUB;
            pc_write   = 1'b1;
            pc_source  = {1'b0, bcond};
            next_state = S_IF;
          end
        end
        S_MEM: begin
          i_or_d    = 1'b1;
          mem_read  = is_lwd;
          mem_write = is_swd;
          if (mem_done) begin
            pc_write   = is_swd;
            next_state = is_swd ? S_IF : S_WB;
          end
        end
        S_WB: begin
          reg_write  = wb_valid;
          rt_dest    = is_imm_alu || is_lwd;
          reg_src    = is_lwd ? 2'd1 : 2'd0;
          pc_write   = 1'b1;
          next_state = S_IF;
        end
        S_HALT: is_halted = 1'b1;
        default: next_state = S_IF;
      endcase
    end
  end

  assign retire = ((state != S_IF) && (next_state == S_IF)) ||
                  ((state == S_ID) && (next_state == S_HALT));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    num_inst <= 16'd0;
    else if (retire) num_inst <= num_inst + 16'd1;
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus pushes per-instruction expectations from an ISA-level model,
// a monitor accumulates what the DUT does over each instruction and compares when it retires.
`timescale 1ns/1ps
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] instr = 16'd0;
  logic        bcond = 1'b0;
  logic        mem_ready = 1'b0;
  logic        i_or_d, mem_read, mem_write, ir_write, alu_src_a, rt_dest, link_dest;
  logic        reg_write, pc_write, output_valid, is_halted;
  logic [1:0]  alu_src_b, reg_src, pc_source;
  logic [2:0]  alu_op;
  logic [15:0] num_inst;
  logic [18:0] ctrl_bus;

  multicycle_control dut (
    .clk(clk), .reset_n(reset_n), .instr(instr), .bcond(bcond), .mem_ready(mem_ready),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .rt_dest(rt_dest),
    .link_dest(link_dest), .reg_src(reg_src), .reg_write(reg_write), .pc_write(pc_write),
    .pc_source(pc_source), .output_valid(output_valid), .is_halted(is_halted), .num_inst(num_inst)
  );

  assign ctrl_bus = {i_or_d, mem_read, mem_write, ir_write, alu_src_a, alu_src_b, alu_op, rt_dest,
                     link_dest, reg_src, reg_write, pc_write, pc_source, output_valid};

  always #5 clk = ~clk;

`ifdef MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  typedef struct {
    int cycles; int halt; int pc_src; int rw; int rw_link; int rw_rt; int rw_src;
    int ov; int mrd; int mwr; int iod; int ex_idx;
    int chk_op; int alu_op; int chk_srcb; int srcb; int chk_srca; int num_exp;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0, failures = 0, issued = 0, retired = 0, model_count = 0;
  int if_wait = 0, mem_wait = 0, acc_cnt = 0, mon_idx;
  int o_cyc, o_irw, o_mrd, o_mwr, o_iod, o_ov, o_rw, o_link, o_rt, o_src, o_op, o_srcb, o_srca;

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ISA-level expectation: cycle counts from the instruction class plus memory wait states
  function automatic exp_t predict(input logic [15:0] ins, input logic bc, input int wi, input int wm,
                                   input int num_before);
    exp_t e;
    int ifc, mc;
    int op, fn;
    op = int'(ins[15:12]);
    fn = int'(ins[5:0]);
    ifc = WAIT_EN ? wi + 1 : 1;
    mc  = WAIT_EN ? wm + 1 : 1;
    e = '{default: 0};
    e.mrd = ifc;
    e.ex_idx = ifc + 1;
    e.num_exp = num_before;
    if (op == 15) begin
      if (fn < 8) begin
        e.cycles = ifc + 3; e.rw = 1;
        e.chk_op = 1; e.alu_op = fn; e.chk_srcb = 1; e.srcb = 0; e.chk_srca = 1;
      end else if (fn == 25) begin
        e.cycles = ifc + 1; e.pc_src = 3;
      end else if (fn == 26) begin
        e.cycles = ifc + 1; e.pc_src = 3; e.rw = 1; e.rw_link = 1; e.rw_src = 2;
      end else if (fn == 28) begin
        e.cycles = ifc + 1; e.ov = 1;
      end else if (fn == 29) begin
        e.cycles = ifc + 1; e.halt = 1; e.num_exp = (num_before + 1) & 16'hFFFF;
      end else begin
        e.cycles = ifc + 3;
      end
    end else begin
      case (op)
        0, 1, 2, 3: begin e.cycles = ifc + 2; e.pc_src = bc ? 1 : 0; e.chk_op = 1; e.alu_op = 1; end
        4: begin e.cycles = ifc + 3; e.rw = 1; e.rw_rt = 1; e.chk_op = 1; e.chk_srcb = 1; e.srcb = 1; end
        5: begin e.cycles = ifc + 3; e.rw = 1; e.rw_rt = 1; e.chk_op = 1; e.alu_op = 3; e.chk_srcb = 1; e.srcb = 3; end
        6: begin e.cycles = ifc + 3; e.rw = 1; e.rw_rt = 1; e.chk_op = 1; e.alu_op = 6; e.chk_srcb = 1; e.srcb = 3; end
        7: begin
          e.cycles = ifc + 3 + mc; e.rw = 1; e.rw_rt = 1; e.rw_src = 1;
          e.mrd = ifc + mc; e.iod = mc; e.chk_op = 1; e.chk_srcb = 1; e.srcb = 1;
        end
        8: begin
          e.cycles = ifc + 2 + mc; e.mwr = mc; e.iod = mc; e.chk_op = 1; e.chk_srcb = 1; e.srcb = 1;
        end
        9:  begin e.cycles = ifc + 1; e.pc_src = 2; end
        10: begin e.cycles = ifc + 1; e.pc_src = 2; e.rw = 1; e.rw_link = 1; e.rw_src = 2; end
        default: e.cycles = ifc + 3;
      endcase
    end
    return e;
  endfunction

  task automatic clear_obs();
    o_cyc = 0; o_irw = 0; o_mrd = 0; o_mwr = 0; o_iod = 0; o_ov = 0; o_rw = 0;
    o_link = -1; o_rt = -1; o_src = -1; o_op = -1; o_srcb = -1; o_srca = -1;
  endtask

  task automatic finish_instr(input int halted, input int pcs);
    exp_t e;
    e = sb_q.pop_front();
    check_output("cycles", o_cyc, e.cycles);
    check_output("halted", halted, e.halt);
    if (e.halt == 0) check_output("pc_source", pcs, e.pc_src);
    check_output("reg_write_cycles", o_rw, e.rw);
    if (e.rw > 0 && o_rw > 0) begin
      check_output("link_dest", o_link, e.rw_link);
      check_output("rt_dest", o_rt, e.rw_rt);
      check_output("reg_src", o_src, e.rw_src);
    end
    check_output("output_valid_cycles", o_ov, e.ov);
    check_output("ir_write_cycles", o_irw, 1);
    check_output("mem_read_cycles", o_mrd, e.mrd);
    check_output("mem_write_cycles", o_mwr, e.mwr);
    check_output("i_or_d_cycles", o_iod, e.iod);
    if (e.chk_op != 0)   check_output("alu_op", o_op, e.alu_op);
    if (e.chk_srcb != 0) check_output("alu_src_b", o_srcb, e.srcb);
    if (e.chk_srca != 0) check_output("alu_src_a", o_srca, 1);
    check_output("num_inst", int'(num_inst), e.num_exp);
    retired++;
    clear_obs();
  endtask

  // Memory model: waits the programmed number of cycles per access, random mem_ready when idle
  always @(negedge clk) begin
    #1;
    if (reset_n && (mem_read || mem_write)) begin
      if (acc_cnt < (i_or_d ? mem_wait : if_wait)) begin
        mem_ready = 1'b0;
        acc_cnt++;
      end else begin
        mem_ready = 1'b1;
        acc_cnt = 0;
      end
    end else begin
      mem_ready = 1'($urandom_range(0, 1));
      acc_cnt = 0;
    end
  end

  // Monitor: one sample per cycle, just before the rising edge
  always @(negedge clk) begin
    #4;
    if (!reset_n) begin
      clear_obs();
    end else if (sb_q.size() > 0) begin
      if (is_halted) begin
        finish_instr(1, 0);
      end else begin
        mon_idx = o_cyc;
        o_cyc++;
        o_irw += int'(ir_write);
        o_mrd += int'(mem_read);
        o_mwr += int'(mem_write);
        o_iod += int'(i_or_d);
        o_ov  += int'(output_valid);
        if (reg_write) begin
          o_rw++;
          o_link = int'(link_dest); o_rt = int'(rt_dest); o_src = int'(reg_src);
        end
        if (mon_idx == sb_q[0].ex_idx) begin
          o_op = int'(alu_op); o_srcb = int'(alu_src_b); o_srca = int'(alu_src_a);
        end
        if (pc_write) finish_instr(0, int'(pc_source));
      end
    end
  end

  task automatic wait_retire();
    int n;
    n = 0;
    while (retired < issued && n < 80) begin
      @(posedge clk);
      n++;
    end
    if (retired < issued) begin
      check_output("retire_timeout", retired, issued);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    sb_q.delete();
    retired = issued;
    model_count = 0;
    #2;
    check_output("reset_ctrl_bus", int'(ctrl_bus), 0);
    check_output("reset_num_inst", int'(num_inst), 0);
    check_output("reset_is_halted", int'(is_halted), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic issue(input logic [15:0] ins, input logic bc, input int wi, input int wm);
    @(negedge clk);
    instr = ins; bcond = bc; if_wait = wi; mem_wait = wm;
    sb_q.push_back(predict(ins, bc, wi, wm, model_count));
    issued++;
    model_count = (model_count + 1) & 16'hFFFF;
  endtask

  task automatic apply_stimulus(input logic [15:0] ins, input logic bc, input int wi, input int wm,
                                input bit chk_if);
    issue(ins, bc, wi, wm);
    if (chk_if) begin
      #2;
      check_output("first_if_mem_read", int'(mem_read), 1);
      check_output("first_if_i_or_d", int'(i_or_d), 0);
    end
    wait_retire();
  endtask

  function automatic logic [15:0] random_instr();
    logic [15:0] r;
    int op, k, fn;
    r = 16'($urandom);
    op = $urandom_range(0, 15);
    r[15:12] = 4'(op);
    if (op == 15) begin
      k = $urandom_range(0, 3);
      case (k)
        1: begin
          fn = $urandom_range(0, 2);
          r[5:0] = (fn == 0) ? 6'd25 : (fn == 1) ? 6'd26 : 6'd28;
        end
        2:       r[5:0] = 6'($urandom_range(8, 24));
        default: r[5:0] = 6'($urandom_range(0, 7));
      endcase
    end
    return r;
  endfunction

  initial begin
    int n;
    clear_obs();
    do_reset();

    // SWD interrupted by reset while its store is on the bus
    issue(16'h8623, 1'b0, 0, 2);
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while (!mem_write && n < 20);
    check_output("swd_reached_mem", int'(mem_write), 1);
    reset_n = 1'b0;
    sb_q.delete();
    retired = issued;
    model_count = 0;
    #1;
    check_output("mid_mem_reset_mem_write", int'(mem_write), 0);
    check_output("mid_mem_reset_ctrl_bus", int'(ctrl_bus), 0);
    check_output("mid_mem_reset_num_inst", int'(num_inst), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    apply_stimulus(16'hFB40, 1'b0, 0, 0, 1'b1);   // ADD $1,$2,$3
    apply_stimulus(16'h7623, 1'b0, 0, 3, 1'b0);   // LWD with three wait cycles in MEM
    apply_stimulus(16'h1405, 1'b1, 0, 0, 1'b0);   // BEQ taken
    apply_stimulus(16'h1405, 1'b0, 0, 0, 1'b0);   // BEQ not taken
    apply_stimulus(16'hA123, 1'b0, 0, 0, 1'b0);   // JAL 0x123

    for (int i = 0; i < 200; i++) begin
      apply_stimulus(random_instr(), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                     $urandom_range(0, 3), 1'b0);
    end

    do_reset();
    apply_stimulus(16'hF41C, 1'b0, 1, 0, 1'b1);   // WWD $1
    apply_stimulus(16'hF01D, 1'b0, 0, 0, 1'b0);   // HLT
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #2;
      check_output("halt_sticky", int'(is_halted), 1);
      check_output("halt_num_inst_frozen", int'(num_inst), model_count);
      check_output("halt_no_enables", int'(ctrl_bus), 0);
    end
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle control FSM for the 16-bit TSC CPU. Sequences the shared datapath through IF/ID/EX/MEM/WB: one memory port, one ALU, one register file.
- Emits per-state datapath selects and write enables.
- Handshakes with the unified instruction/data memory.
- Counts retired instructions.
- Sits between the instruction register and the datapath in cpu.v.

Parameters:
- WORD_SIZE, 16, instruction/data width; uses the `WORD_SIZE define.
- JAL_LINK_REG, 2, register index written by JAL/JRL.

Ports:
- clk  input  1  clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- instr  input  16  current IR contents; opcode [15:12], func [5:0]
- bcond  input  1  branch condition from datapath comparator, valid in EX
- mem_ready  input  1  memory has completed the current read/write
- i_or_d  output  1  0 = memory address from PC, 1 = from ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  latch memory data into IR
- alu_src_a  output  1  0 = PC, 1 = rs data
- alu_src_b  output  2  0 = rt data, 1 = sign-extended imm, 2 = constant 1, 3 = zero-extended imm
- alu_op  output  3  FUNC_* code
- rt_dest  output  1  write register is rt, not rd
- link_dest  output  1  write register is JAL_LINK_REG
- reg_src  output  2  0 = ALUOut, 1 = MDR, 2 = PC+1
- reg_write  output  1  register file write enable
- pc_write  output  1  unconditional PC update
- pc_source  output  2  0 = PC+1, 1 = PC+1+imm, 2 = {PC[15:12], target}, 3 = rs data
- output_valid  output  1  one-cycle pulse for WWD; datapath drives rs to the output port
- is_halted  output  1  HLT retired
- num_inst  output  16  retired-instruction count

Behaviour:
- States: IF, ID, EX, MEM, WB, HALT.
- Reset (async, reset_n low):
  - State goes to IF; num_inst = 0; is_halted = 0.
  - All enables/strobes are 0; all selects are 0.
  - Reset may be asserted in any state. After it, the next rising edge with reset_n high begins a fresh IF; no partial write is ever emitted.
- Outputs are decoded combinationally from the registered state and instr. Every enable not listed for a state is 0.
- IF:
  - i_or_d = 0, mem_read = 1, ir_write = mem_ready.
  - Stay in IF until mem_ready = 1, then go to ID.
- ID:
  - JMP: pc_write = 1, pc_source = 2.
  - JAL: JMP outputs plus reg_write = 1, link_dest = 1, reg_src = 2.
  - JPR: pc_write = 1, pc_source = 3.
  - JRL: JPR outputs plus reg_write = 1, link_dest = 1, reg_src = 2.
  - WWD: output_valid = 1, pc_write = 1, pc_source = 0.
  - Next state: all five of the above go to IF. HLT goes to HALT. Every other opcode goes to EX.
- EX:
  - ALU R-type: alu_src_a = 1, alu_src_b = 0, alu_op from func. Go to WB.
  - ADI/LWD/SWD: alu_src_b = 1, alu_op = FUNC_ADD.
  - ORI: alu_src_b = 3, alu_op = FUNC_ORR.
  - LHI: alu_src_b = 3, alu_op = FUNC_SHL (datapath shifts by 8).
  - ADI/ORI/LHI go to WB. LWD/SWD go to MEM.
  - BNE/BEQ/BGZ/BLZ: alu_op = FUNC_SUB, pc_write = 1, pc_source = bcond ? 1 : 0. Go to IF.
- MEM:
  - i_or_d = 1. LWD: mem_read = 1. SWD: mem_write = 1.
  - Hold until mem_ready. Then LWD goes to WB. SWD asserts pc_write (source 0) in the ready cycle and goes to IF.
- WB:
  - reg_write = 1; rt_dest = 1 for I-type and LWD; reg_src = 1 for LWD, else 0.
  - pc_write = 1, pc_source = 0. Go to IF.
- HALT:
  - is_halted = 1, sticky until reset; no enables asserted.
- num_inst:
  - Increments by 1 on every edge where the FSM leaves a final state for an instruction. Final states: ID→IF, EX→IF, MEM→IF, WB→IF, ID→HALT.
  - Wraps 0xFFFF→0x0000.
- PC update: exactly one pc_write per retired instruction, in its final cycle.
- Unknown opcode or func: treated as a NOP. Go from ID to EX to WB with reg_write forced to 0, then PC+1. The instruction is counted.

Optional Feature:
- Macro: MEM_WAIT_EN.
- Defined: IF and MEM stall on mem_ready as described above.
- Undefined: mem_ready is ignored and treated as 1. Every memory access takes exactly one cycle. The port remains but is unused.

Test Plan:
- Reset mid-MEM of SWD (deassert reset_n while mem_write = 1) -> mem_write drops immediately, state is IF, num_inst = 0; first IF after release has mem_read = 1.
- ADD $1,$2,$3 with mem_ready = 1 -> 4 cycles IF, ID, EX, WB; reg_write = 1 only in WB; num_inst 0→1.
- LWD with mem_ready low for 3 cycles in MEM (MEM_WAIT_EN) -> MEM held 4 cycles; total 8 cycles; reg_src = 1 in WB.
- BEQ with bcond = 1, then bcond = 0 -> EX shows pc_source = 1, then pc_source = 0; both 3 cycles; no reg_write.
- JAL 0x123 -> ID: pc_write = 1, pc_source = 2, reg_write = 1, link_dest = 1, reg_src = 2; 2 cycles total.
- WWD then HLT -> output_valid pulses exactly 1 cycle; after HLT, is_halted = 1, num_inst = 2 and frozen for 10 further cycles.
